// File: rtl/parking_access_fsm.sv
// Multi-floor parking access controller: keypad ID entry, per-floor free-slot counters, admin reload.
// Optional backspace editing is built when PARK_BACKSPACE_EN is defined.
module parking_access_fsm #(
   parameter int unsigned NUM_FLOORS      = 2,
   parameter int unsigned SLOTS_PER_FLOOR = 9,
   parameter int unsigned ID_DIGITS       = 7,
   parameter int unsigned TICK_DIV        = 50000000,
   parameter int unsigned TIMEOUT_TICKS   = 4,
   parameter int unsigned HOLD_TICKS      = 2,
   parameter logic [31:0] ADMIN_CODE      = 32'h1234567,
   localparam int unsigned FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   power,
   input  logic [FW-1:0]          flr,
   input  logic                   key_valid,
   input  logic [3:0]             key_code,
   input  logic                   key_esc,
   input  logic                   key_ctrla,
   input  logic                   key_bksp,
   output logic [4*ID_DIGITS-1:0] id,
   output logic [3:0]             digit_cnt,
   output logic [3:0]             lcd_state,
   output logic                   red_power_led,
   output logic                   red_wrong_led,
   output logic                   green_led,
   output logic [7:0]             free_sel,
   output logic [11:0]            free_total,
   output logic                   grant,
   output logic                   deny
);

   localparam int unsigned IdW      = 4 * ID_DIGITS;
   localparam int unsigned DivW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned MaxTicks = (TIMEOUT_TICKS > HOLD_TICKS) ? TIMEOUT_TICKS : HOLD_TICKS;
   localparam int unsigned TickW    = (MaxTicks > 1) ? $clog2(MaxTicks + 1) : 1;

   localparam logic [DivW-1:0]  DivLast     = DivW'(TICK_DIV - 1);
   localparam logic [TickW-1:0] TimeoutLast = TickW'(TIMEOUT_TICKS - 1);
   localparam logic [TickW-1:0] HoldLast    = TickW'(HOLD_TICKS - 1);
   localparam logic [7:0]       SlotsFull   = 8'(SLOTS_PER_FLOOR);
   localparam logic [3:0]       DigitsFull  = 4'(ID_DIGITS);
   localparam logic [FW:0]      NumFloorsW  = (FW + 1)'(NUM_FLOORS);
   localparam logic [11:0]      TotalFull   = 12'(NUM_FLOORS * SLOTS_PER_FLOOR);
   localparam logic [IdW-1:0]   AdminId     = ADMIN_CODE[IdW-1:0];

   typedef enum logic [2:0] {
      StOff, StIdle, StEntry, StExit, StAdmin, StGrant, StDeny
   } state_e;

   state_e           state_q, state_d;
   logic [IdW-1:0]   id_q, id_d;
   logic [3:0]       dcnt_q, dcnt_d;
   logic [7:0]       cnt_q [NUM_FLOORS];
   logic [7:0]       cnt_d [NUM_FLOORS];
   logic [11:0]      total_q, total_d;
   logic [DivW-1:0]  div_q;
   logic [TickW-1:0] tick_cnt_q;
   logic             grant_q, deny_q;

   logic       tick, timer_clr, key_acc, flr_ok, is_digit, bksp_hit;
   logic [7:0] cur_cnt;

`ifdef PARK_BACKSPACE_EN
   assign bksp_hit = key_valid && key_bksp && !key_esc && !key_ctrla;
`else
   logic unused_bksp;
   assign unused_bksp = key_bksp;
   assign bksp_hit    = 1'b0;
`endif

   assign is_digit = key_valid && !key_esc && !key_ctrla && !bksp_hit && (key_code <= 4'd9);
   assign flr_ok   = {1'b0, flr} < NumFloorsW;
   assign cur_cnt  = flr_ok ? cnt_q[flr] : 8'd0;
   assign tick     = (div_q == DivLast);

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      dcnt_d  = dcnt_q;
      cnt_d   = cnt_q;
      key_acc = 1'b0;
      if (!power) begin
         state_d = StOff;
      end else begin
         unique case (state_q)
            StOff: state_d = StIdle;
            StIdle: begin
               if (key_valid && key_esc) begin
                  state_d = StExit;
                  key_acc = 1'b1;
               end else if (key_valid && key_ctrla) begin
                  state_d = StAdmin;
                  key_acc = 1'b1;
               end else if (is_digit) begin
                  state_d = StEntry;
                  id_d    = IdW'(key_code);
                  dcnt_d  = 4'd1;
                  key_acc = 1'b1;
               end
            end
            StEntry, StExit, StAdmin: begin
               if (dcnt_q == DigitsFull) begin
                  // Full ID: keys on this cycle are dropped in favour of evaluation.
                  state_d = StDeny;
                  if (flr_ok) begin
                     if (state_q == StEntry && cur_cnt != 8'd0) begin
                        cnt_d[flr] = cur_cnt - 8'd1;
                        state_d    = StGrant;
                     end else if (state_q == StExit && cur_cnt < SlotsFull) begin
                        cnt_d[flr] = cur_cnt + 8'd1;
                        state_d    = StGrant;
                     end else if (state_q == StAdmin && id_q == AdminId) begin
                        for (int i = 0; i < NUM_FLOORS; i++) cnt_d[i] = SlotsFull;
                        state_d = StGrant;
                     end
                  end
               end else if (key_valid && key_esc) begin
                  state_d = StIdle;
`ifdef PARK_BACKSPACE_EN
               end else if (bksp_hit) begin
                  if (dcnt_q != 4'd0) begin
                     id_d    = id_q >> 4;
                     dcnt_d  = dcnt_q - 4'd1;
                     key_acc = 1'b1;
                  end
`endif
               end else if (is_digit) begin
                  id_d    = (id_q << 4) | IdW'(key_code);
                  dcnt_d  = dcnt_q + 4'd1;
                  key_acc = 1'b1;
               end else if (tick && tick_cnt_q == TimeoutLast) begin
                  state_d = StIdle;
               end
            end
            StGrant, StDeny: begin
               if (tick && tick_cnt_q == HoldLast) state_d = StIdle;
            end
            default: state_d = StOff;
         endcase
      end
      // Every path back to OFF or IDLE abandons the ID being built.
      if (state_d == StOff || state_d == StIdle) begin
         id_d   = '0;
         dcnt_d = 4'd0;
      end
   end

   assign timer_clr = (state_d != state_q) || key_acc;

   always_comb begin
      total_d = 12'd0;
      for (int i = 0; i < NUM_FLOORS; i++) total_d = total_d + 12'(cnt_q[i]);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= StOff;
         id_q       <= '0;
         dcnt_q     <= 4'd0;
         for (int i = 0; i < NUM_FLOORS; i++) cnt_q[i] <= SlotsFull;
         total_q    <= TotalFull;
         div_q      <= '0;
         tick_cnt_q <= '0;
         grant_q    <= 1'b0;
         deny_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         dcnt_q  <= dcnt_d;
         cnt_q   <= cnt_d;
         total_q <= total_d;
         grant_q <= (state_d == StGrant) && (state_q != StGrant);
         deny_q  <= (state_d == StDeny) && (state_q != StDeny);
         if (timer_clr) begin
            div_q      <= '0;
            tick_cnt_q <= '0;
         end else if (tick) begin
            div_q      <= '0;
            tick_cnt_q <= tick_cnt_q + 1'b1;
         end else begin
            div_q <= div_q + 1'b1;
         end
      end
   end

   always_comb begin
      lcd_state     = 4'd15;
      red_power_led = 1'b0;
      red_wrong_led = 1'b1;
      green_led     = 1'b0;
      unique case (state_q)
         StOff: ;
         StIdle: begin
            lcd_state = 4'd0;
            {red_power_led, red_wrong_led, green_led} = 3'b100;
         end
         StEntry: begin
            lcd_state = 4'd0;
            {red_power_led, red_wrong_led, green_led} = 3'b101;
         end
         StExit: begin
            lcd_state = 4'd3;
            {red_power_led, red_wrong_led, green_led} = 3'b101;
         end
         StAdmin: begin
            lcd_state = 4'd4;
            {red_power_led, red_wrong_led, green_led} = 3'b110;
         end
         StGrant: begin
            lcd_state = 4'd1;
            {red_power_led, red_wrong_led, green_led} = 3'b101;
         end
         StDeny: begin
            lcd_state = 4'd2;
            {red_power_led, red_wrong_led, green_led} = 3'b110;
         end
         default: ;
      endcase
   end

   assign id         = id_q;
   assign digit_cnt  = dcnt_q;
   assign free_sel   = cur_cnt;
   assign free_total = total_q;
   assign grant      = grant_q;
   assign deny       = deny_q;

endmodule

// File: doc/parking_access_fsm.md
Name: parking_access_fsm

Overview:
Multi-floor parking access controller, the parametrised successor of the single-floor PS/2-driven parking controller. Consumes decoded keypad events and assembles an N-digit user ID. Runs entry, exit and admin transactions against per-floor free-slot counters. Drives the LCD state code, status LEDs, and grant/deny strobes for the LCD, 7-segment and gate logic in the top level.

Parameters:
NUM_FLOORS, 2, number of floors (1..8)
SLOTS_PER_FLOOR, 9, capacity per floor (1..255)
ID_DIGITS, 7, BCD digits per ID (1..8)
TICK_DIV, 50000000, clk cycles per 1 s tick
TIMEOUT_TICKS, 4, idle ticks before an input session is abandoned
HOLD_TICKS, 2, ticks a GRANT/DENY result is held
ADMIN_CODE, 28'h1234567, admin ID (low 4*ID_DIGITS bits used)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
power  input  1  system enable; low forces OFF
flr  input  FW=max(1,clog2(NUM_FLOORS))  selected floor
key_valid  input  1  one-cycle key strobe
key_code  input  4  digit 0-9; 10-15 ignored
key_esc  input  1  ESC qualifier, valid with key_valid
key_ctrla  input  1  Ctrl+A qualifier, valid with key_valid
key_bksp  input  1  backspace qualifier, valid with key_valid
id  output  4*ID_DIGITS  assembled ID; newest digit in [3:0]
digit_cnt  output  4  digits currently held
lcd_state  output  4  15 OFF, 0 IDLE/ENTRY, 1 GRANT, 2 DENY, 3 EXIT, 4 ADMIN
red_power_led, red_wrong_led, green_led  output  1 each  status LEDs
free_sel  output  8  free slots on floor flr (combinational read)
free_total  output  12  sum of free slots over all floors
grant, deny  output  1 each  one-cycle result pulses

Behaviour:
- Reset (reset==0 at clk edge) overrides power. Reset values: state OFF, every floor counter = SLOTS_PER_FLOOR, id=0, digit_cnt=0, tick and divider cleared, grant=deny=0, lcd_state=15, LEDs {power,wrong,green}={0,1,0}.
- States: OFF, IDLE, ENTRY, EXIT, ADMIN, GRANT, DENY.
- In any state, power==0 sends the FSM to OFF on the next edge.
- Entering OFF clears id and digit_cnt. Floor counters are retained.
- OFF -> IDLE when power==1.
- Mode flag: 0 = entry, 1 = exit, 2 = admin.
- IDLE, key event, qualifier priority esc > ctrla > digit:
  - esc -> EXIT, flag exit.
  - ctrla -> ADMIN, flag admin.
  - digit 0-9 -> ENTRY, flag entry; the digit is the first one stored.
- ENTRY, EXIT and ADMIN collect digits. Each digit does id <= {id, key_code} and increments digit_cnt.
- key_esc inside a collecting state aborts to IDLE and clears id.
- Timeout: the tick counter clears on state entry and on every accepted key. At TIMEOUT_TICKS ticks with no key, the FSM goes to IDLE and clears id.
- Completion: the digit that makes digit_cnt reach ID_DIGITS is evaluated on the next edge. flr is sampled on that edge.
  - Entry: if cnt[flr] > 0, decrement it and go to GRANT; else go to DENY.
  - Exit: if cnt[flr] < SLOTS_PER_FLOOR, increment it and go to GRANT; else go to DENY (counter saturates).
  - Admin: if id == ADMIN_CODE, reload all counters to full and go to GRANT; else go to DENY.
  - flr >= NUM_FLOORS always goes to DENY.
- grant/deny pulse high for exactly the first cycle of GRANT/DENY.
- GRANT/DENY hold for HOLD_TICKS ticks, then return to IDLE and clear id. Keys are ignored while holding.
- LEDs {power,wrong,green}: IDLE 100, collecting 101, GRANT 101, DENY 110, ADMIN 110.
- lcd_state for ENTRY is 0.
- free_total is a registered sum: one cycle latency after any counter change.

Optional Feature:
PARK_BACKSPACE_EN.
- Defined: key_valid with key_bksp, in a collecting state with digit_cnt > 0, does id <= id >> 4 and decrements digit_cnt. It counts as a key for timeout purposes. Backspace at digit_cnt == 0 is ignored.
- Undefined: key_bksp is ignored entirely and the logic is not synthesised.

Test Plan:
Settings for all scenarios: NUM_FLOORS=2, SLOTS_PER_FLOOR=3, ID_DIGITS=4, TICK_DIV=10, TIMEOUT_TICKS=4, HOLD_TICKS=2.
1. Reset, power=1, flr=1, keys 1,2,3,4 -> one grant pulse; cnt[1]=2; free_total=5; GRANT for 20 cycles, then IDLE with id=0.
2. Four entries on flr=0 -> the first three grant (cnt[0] reaches 0); the fourth gives a deny pulse with lcd_state=2 and cnt[0] stays 0.
3. ESC, keys 5,5,5,5 at flr=1 with cnt[1]=3 -> deny and cnt[1] stays 3. After one prior entry on flr=1, the same sequence grants and restores cnt[1]=3.
4. Key 7, then no keys for 40 cycles -> return to IDLE with id=0 and digit_cnt=0. The same test with a key every 30 cycles must not time out.
5. Ctrl+A, then 4,5,6,7 (matching ADMIN_CODE) after depleting floors -> grant and all counters =3. Ctrl+A, then 9,9,9,9 -> deny with counters unchanged.
6. power=0 mid-entry after 2 digits -> OFF next cycle, id=0, counters kept. Separately, reset=0 together with key_valid -> reset wins and counters reload. With PARK_BACKSPACE_EN: keys 1,2, backspace, 3,4,5 -> id=16'h1345.
